// File: rtl/piso_arbiter.sv
// Round-robin arbiter feeding a parallel-in/serial-out shifter: one granted word per frame, LSB first.
// Optional even-parity bit after the data bits when PISO_ARBITER_PARITY_EN is defined.
module piso_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        ser_valid_o,
    output logic                        ser_data_o,
    output logic                        ser_sof_o,
    output logic [$clog2(NUM_REQ)-1:0]  ser_id_o,
    output logic                        busy_o
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(DATA_W);
    localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
`ifdef PISO_ARBITER_PARITY_EN
        , PARITY = 2'd3
`endif
    } state_t;

    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]         gap_cnt_q, gap_cnt_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_data_q, ser_data_d;
    logic               ser_sof_q, ser_sof_d;
    logic               busy_q, busy_d;
`ifdef PISO_ARBITER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic [DATA_W-1:0]  word;

    // Round-robin search starting one past the last requester served.
    always_comb begin
        int k;
        k         = 0;
        grant_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = (int'(last_grant_q) + i) % NUM_REQ;
            if (req_valid_i[k]) grant_idx = IDW'(k);
        end
    end

    assign accept = (state_q == IDLE) && !rst_i && (|req_valid_i);
    assign word   = req_data_i[int'(grant_idx)*DATA_W +: DATA_W];

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: if (bit_cnt_q == '0) begin
`ifdef PISO_ARBITER_PARITY_EN
                state_d = PARITY;
`else
                state_d = AFTER_FRAME;
`endif
            end
`ifdef PISO_ARBITER_PARITY_EN
            PARITY: state_d = AFTER_FRAME;
`endif
            GAP:   if (gap_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Serial outputs are precomputed here and registered so they line up with state_q.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        ser_valid_d  = 1'b0;
        ser_data_d   = 1'b0;
        ser_sof_d    = 1'b0;
`ifdef PISO_ARBITER_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                shreg_d      = word >> 1;
                bit_cnt_d    = CW'(DATA_W - 1);
                id_d         = grant_idx;
                last_grant_d = grant_idx;
                ser_valid_d  = 1'b1;
                ser_data_d   = word[0];
                ser_sof_d    = 1'b1;
`ifdef PISO_ARBITER_PARITY_EN
                parity_d     = ^word;
`endif
            end
            SHIFT: if (bit_cnt_q != '0) begin
                ser_valid_d = 1'b1;
                ser_data_d  = shreg_q[0];
                shreg_d     = shreg_q >> 1;
                bit_cnt_d   = bit_cnt_q - 1'b1;
            end else begin
`ifdef PISO_ARBITER_PARITY_EN
                ser_valid_d = 1'b1;
                ser_data_d  = parity_q;
`endif
            end
            GAP: if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
            default: ;
        endcase
        if (state_d == GAP && state_q != GAP) gap_cnt_d = GAP_LOAD;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            ser_valid_q  <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_sof_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PISO_ARBITER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ser_valid_q  <= ser_valid_d;
            ser_data_q   <= ser_data_d;
            ser_sof_q    <= ser_sof_d;
            busy_q       <= busy_d;
`ifdef PISO_ARBITER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign ser_valid_o = ser_valid_q;
    assign ser_data_o  = ser_data_q;
    assign ser_sof_o   = ser_sof_q;
    assign ser_id_o    = id_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_piso_arbiter.sv
// Directed bench for piso_arbiter: default instance plus a GAP_CYCLES=0 instance for back-to-back frames.
module tb_piso_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 4;
    localparam int GAP = 1;
`ifdef PISO_ARBITER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 1 + DW + PAR + GAP;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [NR-1:0]   req_valid_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0]   req_ready_o;
    logic            ser_valid_o, ser_data_o, ser_sof_o, busy_o;
    logic [1:0]      ser_id_o;

    logic [NR-1:0]   z_valid = '0;
    logic [NR*DW-1:0] z_data = '0;
    logic [NR-1:0]   z_ready;
    logic            z_ser_valid, z_ser_data, z_ser_sof, z_busy;
    logic [1:0]      z_ser_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_prev, hs_now;

    piso_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .ser_valid_o(ser_valid_o), .ser_data_o(ser_data_o),
        .ser_sof_o(ser_sof_o), .ser_id_o(ser_id_o), .busy_o(busy_o)
    );

    piso_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0)) u_dut_nogap (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(z_valid), .req_data_i(z_data),
        .req_ready_o(z_ready), .ser_valid_o(z_ser_valid), .ser_data_o(z_ser_data),
        .ser_sof_o(z_ser_sof), .ser_id_o(z_ser_id), .busy_o(z_busy)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] w);
        req_data_i[k*DW +: DW] = w;
    endtask

    // Entered 1 time unit after the handshake edge; leaves in the following IDLE cycle.
    task automatic expect_frame(input int id, input logic [DW-1:0] w);
        for (int b = 0; b < DW; b++) begin
            check("ser_valid", 32'(ser_valid_o), 1);
            check("ser_data", 32'(ser_data_o), 32'(w[b]));
            check("ser_sof", 32'(ser_sof_o), (b == 0) ? 1 : 0);
            check("ser_id", 32'(ser_id_o), id);
            check("busy", 32'(busy_o), 1);
            check("ready_mid", 32'(req_ready_o), 0);
            step();
        end
`ifdef PISO_ARBITER_PARITY_EN
        check("par_valid", 32'(ser_valid_o), 1);
        check("par_bit", 32'(ser_data_o), 32'(^w));
        check("par_sof", 32'(ser_sof_o), 0);
        step();
`endif
        for (int g = 0; g < GAP; g++) begin
            check("gap_valid", 32'(ser_valid_o), 0);
            check("gap_data", 32'(ser_data_o), 0);
            check("gap_sof", 32'(ser_sof_o), 0);
            check("gap_busy", 32'(busy_o), 1);
            step();
        end
        check("idle_valid", 32'(ser_valid_o), 0);
        check("idle_busy", 32'(busy_o), 0);
    endtask

    initial begin
        // Reset state, with a request already pending
        req_valid_i = 4'b0001;
        set_word(0, 4'hB);
        step();
        step();
        check("rst_valid", 32'(ser_valid_o), 0);
        check("rst_data", 32'(ser_data_o), 0);
        check("rst_sof", 32'(ser_sof_o), 0);
        check("rst_id", 32'(ser_id_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_z_ready", 32'(z_ready), 0);

        // Single frame of 4'hB from requester 0
        rst_i = 1'b0;
        #1;
        check("ready_b", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = '0;
        expect_frame(0, 4'hB);

        // Continuous requests from all four: grants 0,1,2,3,0 at fixed period
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        set_word(0, 4'h3); set_word(1, 4'h5); set_word(2, 4'h9); set_word(3, 4'hC);
        req_valid_i = 4'b1111;
        hs_prev = 0;
        for (int f = 0; f < 5; f++) begin
            #1;
            check("rr_ready", 32'(req_ready_o), 32'(1 << (f % NR)));
            hs_now = cyc;
            if (f > 0) check("rr_period", hs_now - hs_prev, FRAME);
            hs_prev = hs_now;
            step();
            case (f % NR)
                0: expect_frame(0, 4'h3);
                1: expect_frame(1, 4'h5);
                2: expect_frame(2, 4'h9);
                default: expect_frame(3, 4'hC);
            endcase
        end
        req_valid_i = '0;

        // Requester 2 served, then 1 and 3 compete: 3 before 1
        req_valid_i = 4'b0100;
        set_word(2, 4'h7);
        #1;
        check("rr2_ready", 32'(req_ready_o), 32'h4);
        step();
        req_valid_i = 4'b1010;
        set_word(1, 4'h5);
        set_word(3, 4'h6);
        expect_frame(2, 4'h7);
        #1;
        check("rr3_ready", 32'(req_ready_o), 32'h8);
        step();
        req_valid_i = 4'b0010;
        expect_frame(3, 4'h6);
        #1;
        check("rr1_ready", 32'(req_ready_o), 32'h2);
        step();
        req_valid_i = '0;
        expect_frame(1, 4'h5);

        // Request withdrawn before an edge: no grant, pointer unchanged
        req_valid_i = 4'b0001;
        #1;
        check("wd_ready", 32'(req_ready_o), 32'h1);
        req_valid_i = '0;
        step();
        check("wd_busy", 32'(busy_o), 0);
        check("wd_valid", 32'(ser_valid_o), 0);
        req_valid_i = 4'b0101;
        #1;
        check("wd_ptr", 32'(req_ready_o), 32'h4);
        req_valid_i = '0;
        step();

        // Reset on the third bit of 4'hF aborts the frame and restores priority to requester 0
        req_valid_i = 4'b0100;
        set_word(2, 4'hF);
        #1;
        check("ab_ready", 32'(req_ready_o), 32'h4);
        step();
        req_valid_i = '0;
        check("ab_bit0", 32'(ser_valid_o), 1);
        step();
        step();
        check("ab_bit2", 32'(ser_valid_o), 1);
        rst_i = 1'b1;
        req_valid_i = 4'b1001;
        set_word(0, 4'h2);
        set_word(3, 4'hD);
        step();
        check("ab_valid", 32'(ser_valid_o), 0);
        check("ab_data", 32'(ser_data_o), 0);
        check("ab_sof", 32'(ser_sof_o), 0);
        check("ab_id", 32'(ser_id_o), 0);
        check("ab_busy", 32'(busy_o), 0);
        check("ab_ready_rst", 32'(req_ready_o), 0);
        rst_i = 1'b0;
        #1;
        check("ab_regrant", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = 4'b1000;
        expect_frame(0, 4'h2);
        #1;
        check("ab_next", 32'(req_ready_o), 32'h8);
        step();
        req_valid_i = '0;
        expect_frame(3, 4'hD);

        // Words whose parity differs
        req_valid_i = 4'b0001;
        set_word(0, 4'h7);
        step();
        req_valid_i = '0;
        expect_frame(0, 4'h7);
        req_valid_i = 4'b0010;
        set_word(1, 4'h5);
        step();
        req_valid_i = '0;
        expect_frame(1, 4'h5);

        // Zero-gap instance: requester 1 held valid, one idle accept cycle between frames
        z_valid = 4'b0010;
        z_data[1*DW +: DW] = 4'h6;
        for (int f = 0; f < 3; f++) begin
            #1;
            check("z_ready", 32'(z_ready), 32'h2);
            step();
            for (int b = 0; b < DW + PAR; b++) begin
                check("z_valid", 32'(z_ser_valid), 1);
                if (b < DW) check("z_data", 32'(z_ser_data), 32'((4'h6 >> b) & 1));
                check("z_id", 32'(z_ser_id), 1);
                step();
            end
            check("z_idle_valid", 32'(z_ser_valid), 0);
        end
        z_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_arbiter.md
PISO_ARBITER -- requirements
Module: piso_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 4, parallel word width in bits (2..16).
REQ-003 SHALL have parameter GAP_CYCLES, default 1, idle cycles inserted after each frame (0..7).
REQ-004 SHALL have port clk_i  input  1  clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester word valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port ser_valid_o  output  1  serial bit valid.
REQ-010 SHALL have port ser_data_o  output  1  serial data bit.
REQ-011 SHALL have port ser_sof_o  output  1  high on first bit of a frame only.
REQ-012 SHALL have port ser_id_o  output  $clog2(NUM_REQ)  index of requester owning the current frame.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, SHIFT, PARITY (present only when configured), GAP.
REQ-015 In IDLE with any req_valid_i set, SHALL combinationally drive req_ready_o high for exactly one granted requester; in all other states req_ready_o SHALL be zero.
REQ-016 Grant SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on a completed handshake (valid & ready).
REQ-017 On handshake at edge N, SHALL capture the word and index and enter SHIFT; first serial bit valid in cycle N+1 (latency one cycle).
REQ-018 In SHIFT, SHALL emit the word LSB first, one bit per cycle, for exactly DATA_W cycles, ser_valid_o=1, ser_id_o constant.
REQ-019 After the last data bit, SHALL enter PARITY if configured, else GAP; with GAP_CYCLES=0 SHALL go directly to IDLE.
REQ-020 In GAP, SHALL hold ser_valid_o=0 for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-021 When ser_valid_o=0, ser_data_o and ser_sof_o SHALL be 0.
REQ-022 req_valid_i deasserted before handshake SHALL cause no grant and no pointer change; requesters hold data stable until ready.
REQ-023 Frame period SHALL be 1 (IDLE accept) + DATA_W (+1 parity) + GAP_CYCLES cycles when requests are continuous.
REQ-024 Requests arriving mid-frame SHALL wait; no frame is truncated or reordered except by reset.
REQ-025 All ser_* and busy_o outputs SHALL be registered.

Reset
REQ-026 rst_i high at a rising edge SHALL force state IDLE, last_grant=NUM_REQ-1 (requester 0 highest priority), shift register and counters to 0.
REQ-027 During and after reset: ser_valid_o=0, ser_data_o=0, ser_sof_o=0, ser_id_o=0, busy_o=0, req_ready_o=0 while rst_i is high.
REQ-028 Reset mid-frame SHALL abort the frame; remaining bits are never emitted.

Configuration
REQ-029 Macro PISO_ARBITER_PARITY_EN defined: after the last data bit SHALL emit one PARITY cycle, ser_valid_o=1, ser_data_o = XOR of all captured data bits (even parity), then proceed to GAP.
REQ-030 Macro PISO_ARBITER_PARITY_EN undefined: PARITY state and logic SHALL be absent; SHIFT proceeds directly to GAP/IDLE.

Verification
REQ-031 Defaults, no parity; req 0 valid data 4'hB -> ready[0] one cycle; next cycles ser_data 1,1,0,1, sof on first only, id 0, then 1 gap cycle, busy low.
REQ-032 All four requesters held valid continuously -> grants 0,1,2,3,0 in order, each frame 6 cycles apart.
REQ-033 Req 2 granted, then req 1 and req 3 valid -> next grant 3, then 1.
REQ-034 Reset asserted on third SHIFT bit of 4'hF -> following cycle all outputs 0, state IDLE; next grant goes to req 0 if valid.
REQ-035 PISO_ARBITER_PARITY_EN defined, data 4'h7 -> bits 1,1,1,0 then parity bit 1; data 4'h5 -> parity bit 0.
REQ-036 GAP_CYCLES=0, req 1 continuously valid -> frames back-to-back with one IDLE accept cycle between, no ser_valid_o gap beyond that cycle.
